pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, fetch address after reset.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port stall  input  1  hazard-unit freeze of F/D.
REQ-005 SHALL have port br_valid  input  1  D-stage control-transfer decision valid this cycle.
REQ-006 SHALL have port br_kind  input  2  0 none, 1 NPC target (b/j/jal), 2 register target (jr/jalr), 3 reserved (treated as 0).
REQ-007 SHALL have port npc_target  input  32  branch/jump target from NPC.
REQ-008 SHALL have port jr_target  input  32  forwarded rs value for jr.
REQ-009 SHALL have port jr_ready  input  1  jr_target holds the final forwarded value.
REQ-010 SHALL have port pc  output  32  current fetch address, registered.
REQ-011 SHALL have port pc_add4  output  32  pc+4, combinational.
REQ-012 SHALL have port pc_sel  output  2  source applied at next edge: 0 pc_add4, 1 npc_target/pending, 2 jr_target.
REQ-013 SHALL have port pc_en  output  1  pc updates at next edge.
REQ-014 SHALL have port d_hold  output  1  request to hold D stage while jr waits.
REQ-015 SHALL have port addr_err  output  1  sticky misaligned-target flag.
REQ-016 SHALL have port stall_cnt  output  16  count of cycles with pc_en=0.

Function
REQ-017 SHALL implement FSM states RUN, STALL, JR_WAIT.
REQ-018 pc_add4 SHALL equal pc+4 modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-019 RUN, stall=0, no valid transfer: pc_sel=0, pc_en=1, pc<=pc_add4.
REQ-020 RUN, stall=0, br_valid, kind 1: pc_sel=1, pc_en=1, pc<=npc_target (delay slot already fetched).
REQ-021 RUN, stall=0, br_valid, kind 2, jr_ready=1: pc_sel=2, pc_en=1, pc<=jr_target.
REQ-022 RUN, stall=0, br_valid, kind 2, jr_ready=0: pc_en=0, d_hold=1 combinationally, next state JR_WAIT.
REQ-023 RUN, stall=1: pc_en=0; if br_valid with kind 1, latch npc_target into pending register and set pending flag; next state STALL.
REQ-024 STALL: pc_en=0 while stall=1; br_valid ignored (D frozen upstream).
REQ-025 STALL, stall deasserts: if pending, pc_sel=1, pc<=pending target, clear pending; else pc_sel=0, pc<=pc_add4; next state RUN; update occurs in the same cycle stall reads 0.
REQ-026 JR_WAIT: d_hold=1, pc_en=0 until jr_ready=1 and stall=0; then pc_sel=2, pc<=jr_target, d_hold=0, next state RUN.
REQ-027 JR_WAIT with stall=1 SHALL remain JR_WAIT regardless of jr_ready.
REQ-028 stall SHALL take priority over every transfer in every state.
REQ-029 Any target loaded with bits[1:0]!=0 SHALL set addr_err and load target with bits[1:0] forced to 0.
REQ-030 stall_cnt SHALL increment each cycle pc_en=0, saturating at 16'hFFFF.
REQ-031 pc_sel SHALL read 0 whenever pc_en=0.

Reset
REQ-032 On reset=1 at a rising edge: pc=RESET_PC, state RUN, pending cleared, addr_err=0, stall_cnt=0, regardless of state or in-flight jr/pending.
REQ-033 During the reset cycle outputs SHALL be pc_sel=0, pc_en=0, d_hold=0.

Structure
REQ-034 State encoding, pc_sel encoding (PCSEL_ADD4=0, PCSEL_NPC=1, PCSEL_JR=2), br_kind codes and RESET_PC default SHALL live in a shared package/header used by the mux and controller.
REQ-035 The next-PC selection SHALL be a single sub-module pc_next_mux (three-way select on pc_sel); FSM, pending register and counter stay in pc_sequencer.

Verification
REQ-036 Reset then 3 free cycles -> pc 0x3000,0x3004,0x3008,0x300C; stall_cnt=0.
REQ-037 br_valid kind1 npc_target=0x3100 with stall=1 for 2 cycles, then stall=0 -> pc holds 2 cycles, then 0x3100; stall_cnt=2.
REQ-038 br_valid kind2 jr_target=0x3200, jr_ready=0 for 3 cycles -> d_hold=1 three cycles, pc frozen, then pc=0x3200, pc_sel=2.
REQ-039 pc forced to 0xFFFF_FFFC, one free cycle -> pc=0x0000_0000.
REQ-040 kind1 npc_target=0x3102 -> pc=0x3100, addr_err=1 held until reset.
REQ-041 reset asserted in JR_WAIT with pending set -> next pc=0x3000, d_hold=0, pending cleared, addr_err=0.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared encodings for the PC sequencer: FSM states, next-PC select codes,
// branch-kind codes and the default reset fetch address.
package pc_sequencer_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_STALL   = 2'd1,
        ST_JR_WAIT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        PCSEL_ADD4 = 2'd0,
        PCSEL_NPC  = 2'd1,
        PCSEL_JR   = 2'd2
    } pc_sel_t;

    // br_kind codes 0 (none) and 3 (reserved) both mean "no transfer".
    localparam logic [1:0] BR_NPC = 2'd1;
    localparam logic [1:0] BR_REG = 2'd2;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/pc_sequencer_next_mux.sv
// Three-way next-PC select. Loaded targets are word-aligned on the way out
// and a misaligned transfer target is reported to the controller.
module pc_next_mux
    import pc_sequencer_pkg::*;
(
    input  logic [31:0] i_pc_add4,
    input  logic [31:0] i_npc_src,
    input  logic [31:0] i_jr_target,
    input  pc_sel_t     i_sel,
    output logic [31:0] o_next_pc,
    output logic        o_misaligned
);

    logic [31:0] w_raw;

    always_comb begin
        w_raw = i_pc_add4;
        case (i_sel)
            PCSEL_NPC: w_raw = i_npc_src;
            PCSEL_JR:  w_raw = i_jr_target;
            default:   w_raw = i_pc_add4;
        endcase
    end

    assign o_next_pc    = {w_raw[31:2], 2'b00};
    assign o_misaligned = (i_sel != PCSEL_ADD4) && is_misaligned(w_raw);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-address sequencer: owns the PC register, holds a branch target taken
// during a stall, waits for a late jr operand, and counts frozen cycles.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_valid,
    input  logic [1:0]  br_kind,
    input  logic [31:0] npc_target,
    input  logic [31:0] jr_target,
    input  logic        jr_ready,
    output logic [31:0] pc,
    output logic [31:0] pc_add4,
    output logic [1:0]  pc_sel,
    output logic        pc_en,
    output logic        d_hold,
    output logic        addr_err,
    output logic [15:0] stall_cnt,
    output logic [1:0]  dbg_state
);

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic        r_pend_valid;
    logic [31:0] r_pend_target;
    logic        r_addr_err;
    logic [15:0] r_stall_cnt;

    pc_sel_t     w_pc_sel;
    logic        w_pc_en;
    logic        w_d_hold;
    logic        w_is_npc;
    logic        w_is_reg;
    logic [31:0] w_pc_add4;
    logic [31:0] w_npc_src;
    logic [31:0] w_next_pc;
    logic        w_misaligned;
    logic        w_pend_load;
    logic        w_pend_clear;

    assign w_is_npc  = br_valid && (br_kind == BR_NPC);
    assign w_is_reg  = br_valid && (br_kind == BR_REG);
    assign w_pc_add4 = r_pc + 32'd4;
    // In STALL the NPC input is stale; the parked target is the live one.
    assign w_npc_src = (r_state == ST_STALL) ? r_pend_target : npc_target;

    pc_next_mux u_next_mux (
        .i_pc_add4    (w_pc_add4),
        .i_npc_src    (w_npc_src),
        .i_jr_target  (jr_target),
        .i_sel        (w_pc_sel),
        .o_next_pc    (w_next_pc),
        .o_misaligned (w_misaligned)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_RUN;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN: begin
                if (stall)                      w_state_next = ST_STALL;
                else if (w_is_reg && !jr_ready) w_state_next = ST_JR_WAIT;
            end
            ST_STALL:   if (!stall)             w_state_next = ST_RUN;
            ST_JR_WAIT: if (!stall && jr_ready) w_state_next = ST_RUN;
            default:                            w_state_next = ST_RUN;
        endcase
    end

    always_comb begin
        w_pc_sel = PCSEL_ADD4;
        w_pc_en  = 1'b0;
        w_d_hold = 1'b0;
        if (!reset) begin
            case (r_state)
                ST_RUN: begin
                    if (!stall) begin
                        if (w_is_npc) begin
                            w_pc_en  = 1'b1;
                            w_pc_sel = PCSEL_NPC;
                        end else if (w_is_reg) begin
                            if (jr_ready) begin
                                w_pc_en  = 1'b1;
                                w_pc_sel = PCSEL_JR;
                            end else begin
                                w_d_hold = 1'b1;
                            end
                        end else begin
                            w_pc_en = 1'b1;
                        end
                    end
                end
                ST_STALL: begin
                    if (!stall) begin
                        w_pc_en  = 1'b1;
                        w_pc_sel = r_pend_valid ? PCSEL_NPC : PCSEL_ADD4;
                    end
                end
                ST_JR_WAIT: begin
                    if (!stall && jr_ready) begin
                        w_pc_en  = 1'b1;
                        w_pc_sel = PCSEL_JR;
                    end else begin
                        w_d_hold = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_pend_load  = (r_state == ST_RUN) && stall && w_is_npc;
    assign w_pend_clear = (r_state == ST_STALL) && !stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_pend_valid  <= 1'b0;
            r_pend_target <= 32'd0;
            r_addr_err    <= 1'b0;
            r_stall_cnt   <= 16'd0;
        end else begin
            if (w_pc_en) begin
                r_pc <= w_next_pc;
                if (w_misaligned) r_addr_err <= 1'b1;
            end else if (r_stall_cnt != 16'hFFFF) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (w_pend_load) begin
                r_pend_valid  <= 1'b1;
                r_pend_target <= npc_target;
            end else if (w_pend_clear) begin
                r_pend_valid  <= 1'b0;
            end
        end
    end

    assign pc        = r_pc;
    assign pc_add4   = w_pc_add4;
    assign pc_sel    = w_pc_sel;
    assign pc_en     = w_pc_en;
    assign d_hold    = w_d_hold;
    assign addr_err  = r_addr_err;
    assign stall_cnt = r_stall_cnt;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed scenarios followed by random
// traffic, each cycle predicted by a behavioural model and checked by a monitor.
module tb_pc_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    typedef struct packed {
        logic        full;
        logic [31:0] pc;
        logic [31:0] add4;
        logic        en;
        logic [1:0]  sel;
        logic        hold;
        logic        err;
        logic [15:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        br_valid = 1'b0;
    logic [1:0]  br_kind = 2'd0;
    logic [31:0] npc_target = 32'd0;
    logic [31:0] jr_target = 32'd0;
    logic        jr_ready = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc_add4;
    logic [1:0]  pc_sel;
    logic        pc_en;
    logic        d_hold;
    logic        addr_err;
    logic [15:0] stall_cnt;
    logic [1:0]  dbg_state;

    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;

    // Model: the fetch address, a parked jump target, and whether the front
    // end is frozen by the hazard unit or by an unresolved register jump.
    logic        m_known = 1'b0;
    logic [31:0] m_pc = 32'd0;
    logic        m_err = 1'b0;
    logic [15:0] m_cnt = 16'd0;
    logic        m_frozen = 1'b0;
    logic        m_jr_waiting = 1'b0;
    logic [31:0] m_parked[$];

    pc_sequencer #(.RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .br_valid   (br_valid),
        .br_kind    (br_kind),
        .npc_target (npc_target),
        .jr_target  (jr_target),
        .jr_ready   (jr_ready),
        .pc         (pc),
        .pc_add4    (pc_add4),
        .pc_sel     (pc_sel),
        .pc_en      (pc_en),
        .d_hold     (d_hold),
        .addr_err   (addr_err),
        .stall_cnt  (stall_cnt),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    endtask

    task automatic step(input logic rst, input logic st, input logic bv, input logic [1:0] bk,
                        input logic [31:0] nt, input logic [31:0] jt, input logic jrdy);
        exp_t        e;
        logic        en;
        logic [1:0]  sel;
        logic        hold;
        logic [31:0] tgt;
        @(posedge clk);
        #1;
        reset = rst; stall = st; br_valid = bv; br_kind = bk;
        npc_target = nt; jr_target = jt; jr_ready = jrdy;
        en = 1'b0; sel = 2'd0; hold = 1'b0; tgt = m_pc + 32'd4;
        if (rst) begin
            en = 1'b0;
        end else if (m_jr_waiting) begin
            if (!st && jrdy) begin en = 1'b1; sel = 2'd2; tgt = jt; m_jr_waiting = 1'b0; end
            else hold = 1'b1;
        end else if (m_frozen) begin
            if (!st) begin
                en = 1'b1;
                m_frozen = 1'b0;
                if (m_parked.size() > 0) begin sel = 2'd1; tgt = m_parked.pop_front(); end
            end
        end else if (st) begin
            m_frozen = 1'b1;
            if (bv && bk == 2'd1) m_parked.push_back(nt);
        end else if (bv && bk == 2'd1) begin
            en = 1'b1; sel = 2'd1; tgt = nt;
        end else if (bv && bk == 2'd2) begin
            if (jrdy) begin en = 1'b1; sel = 2'd2; tgt = jt; end
            else begin hold = 1'b1; m_jr_waiting = 1'b1; end
        end else begin
            en = 1'b1;
        end
        e.full = m_known; e.pc = m_pc; e.add4 = m_pc + 32'd4; e.en = en;
        e.sel = sel; e.hold = hold; e.err = m_err; e.cnt = m_cnt;
        exp_q.push_back(e);
        if (rst) begin
            m_known = 1'b1; m_pc = RESET_PC; m_err = 1'b0; m_cnt = 16'd0;
            m_frozen = 1'b0; m_jr_waiting = 1'b0; m_parked.delete();
        end else if (en) begin
            if (tgt % 4 != 0) m_err = 1'b1;
            m_pc = tgt - (tgt % 4);
        end else if (m_cnt != 16'hFFFF) begin
            m_cnt = m_cnt + 16'd1;
        end
    endtask

    task automatic free_run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("pc_en", {31'd0, pc_en}, {31'd0, e.en});
            check("pc_sel", {30'd0, pc_sel}, {30'd0, e.sel});
            check("d_hold", {31'd0, d_hold}, {31'd0, e.hold});
            if (e.full) begin
                check("pc", pc, e.pc);
                check("pc_add4", pc_add4, e.add4);
                check("addr_err", {31'd0, addr_err}, {31'd0, e.err});
                check("stall_cnt", {16'd0, stall_cnt}, {16'd0, e.cnt});
            end
        end
    end

    initial begin
        logic [31:0] t;
        // Reset and free-running fetch
        step(1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0);
        free_run(4);
        // Jump decided while stalled, released after two cycles
        step(1'b0, 1'b1, 1'b1, 2'd1, 32'h0000_3100, 32'd0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 2'd1, 32'h0000_3100, 32'd0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0);
        free_run(2);
        // Register jump waiting three cycles for its operand
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 2'd2, 32'd0, 32'h0000_3200, 1'b0);
        step(1'b0, 1'b0, 1'b1, 2'd2, 32'd0, 32'h0000_3200, 1'b1);
        free_run(1);
        // Operand arrives during a stall: stall wins
        step(1'b0, 1'b0, 1'b1, 2'd2, 32'd0, 32'h0000_3300, 1'b0);
        step(1'b0, 1'b1, 1'b0, 2'd0, 32'd0, 32'h0000_3300, 1'b1);
        step(1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 32'h0000_3300, 1'b1);
        // Reserved kind behaves as no transfer; wrap at top of address space
        step(1'b0, 1'b0, 1'b1, 2'd3, 32'h0000_3400, 32'h0000_3500, 1'b1);
        step(1'b0, 1'b0, 1'b1, 2'd1, 32'hFFFF_FFFC, 32'd0, 1'b0);
        free_run(2);
        // Misaligned target, then reset out of a pending jr wait
        step(1'b0, 1'b0, 1'b1, 2'd1, 32'h0000_3102, 32'd0, 1'b0);
        free_run(3);
        step(1'b0, 1'b1, 1'b1, 2'd1, 32'h0000_3800, 32'd0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 2'd2, 32'd0, 32'h0000_3900, 1'b0);
        step(1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 32'h0000_3900, 1'b1);
        free_run(2);
        // Random traffic
        for (int i = 0; i < 600; i++) begin
            t = 32'h0000_3000 + ($urandom_range(0, 1023) * 4);
            if ($urandom_range(0, 15) == 0) t = t + $urandom_range(1, 3);
            step($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                 2'($urandom_range(0, 3)), t, {t[31:2] ^ 30'h0000_0055, t[1:0]},
                 $urandom_range(0, 4) < 3);
        end
        @(posedge clk);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        n_total++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
